// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants and the dump FSM state type (CSUM state exists only with UART_DUMP_CSUM_EN)
package uart_pkg;
   localparam int UART_DATA_BITS    = 8;
   localparam int UART_FRAME_BITS   = 10;
   localparam int UART_CLKS_PER_BIT = 87;
   typedef enum logic [2:0] {
      IDLE,
      READ,
      LATCH,
      SEND,
      NEXT,
`ifdef UART_DUMP_CSUM_EN
      CSUM,
`endif
      FIN
   } dump_state_t;
endpackage

// File: rtl/uart_dump_tx_if.sv
// uart_dump_tx_if: dump control, memory read port and serial line of uart_dump_tx
interface uart_dump_tx_if #(parameter int ADDR_W = 14);
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W:0]   word_count;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_adr;
   logic [31:0]       rd_data;
   logic              tx;
   logic              busy;
   logic              done;
   modport master (output start, start_addr, word_count, rd_data, input rd_en, rd_adr, tx, busy, done);
   modport slave  (input start, start_addr, word_count, rd_data, output rd_en, rd_adr, tx, busy, done);
endinterface

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer; ready rises in the last stop-bit cycle so bytes chain without gaps
module uart_tx_byte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      valid,
   input  logic [UART_DATA_BITS-1:0] data,
   output logic                      ready,
   output logic                      tx
);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   logic                    active;
   logic [CW-1:0]           baud;
   logic [3:0]              bit_idx;
   logic [UART_DATA_BITS:0] shift;
   logic                    bit_end;
   assign bit_end = baud == CW'(CLKS_PER_BIT - 1);
   assign ready   = !active || (bit_end && bit_idx == 4'(UART_FRAME_BITS - 1));
   // Load a frame on valid&ready, then step one bit every CLKS_PER_BIT cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active  <= 1'b0;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx      <= 1'b1;
      end else if (valid && ready) begin
         active  <= 1'b1;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= {1'b1, data};
         tx      <= 1'b0;
      end else if (active) begin
         baud <= bit_end ? '0 : baud + 1'b1;
         if (bit_end) begin
            bit_idx <= bit_idx + 1'b1;
            tx      <= shift[0];
            shift   <= {1'b1, shift[UART_DATA_BITS:1]};
            if (bit_idx == 4'(UART_FRAME_BITS - 1)) begin
               active <= 1'b0;
               tx     <= 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/uart_dump_tx.sv
// uart_dump_tx: reads a word range from memory and sends each word LSB byte first as 8N1; UART_DUMP_CSUM_EN appends an XOR checksum byte
module uart_dump_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int ADDR_W       = 14
) (
   input logic           clk,
   input logic           rst,
   uart_dump_tx_if.slave bus
);
   dump_state_t     state;
   logic [31:0]     word;
   logic [1:0]      idx;
   logic [ADDR_W:0] remaining;
   logic            byte_valid;
   logic            byte_ready;
   logic [7:0]      byte_data;
   logic            last_word;
`ifdef UART_DUMP_CSUM_EN
   logic [1:0]      gap;
   logic [7:0]      csum;
`endif
   assign last_word = remaining == {{ADDR_W{1'b0}}, 1'b1};
   // Byte 0 goes straight from the read data in LATCH, bytes 1-3 from the held word as the serializer frees up
   always_comb begin
      byte_valid = (state == LATCH) || (state == SEND && byte_ready && idx != 2'd0);
      byte_data  = (state == LATCH) ? bus.rd_data[7:0] : word[{idx, 3'b000} +: 8];
`ifdef UART_DUMP_CSUM_EN
      if (state == CSUM) begin
         byte_valid = gap == 2'd1;
         byte_data  = csum;
      end
`endif
   end
   // Word sequencer: read, capture, send four bytes, advance address with wrap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         bus.rd_en  <= 1'b0;
         bus.rd_adr <= '0;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         word       <= '0;
         idx        <= '0;
         remaining  <= '0;
`ifdef UART_DUMP_CSUM_EN
         gap        <= '0;
         csum       <= '0;
`endif
      end else begin
`ifdef UART_DUMP_CSUM_EN
         if (byte_valid && state != CSUM) csum <= csum ^ byte_data;
`endif
         case (state)
            IDLE: if (bus.start) begin
               bus.rd_adr <= bus.start_addr;
               remaining  <= bus.word_count;
`ifdef UART_DUMP_CSUM_EN
               csum       <= '0;
`endif
               if (bus.word_count == '0) begin
                  state    <= FIN;
                  bus.done <= 1'b1;
               end else begin
                  state     <= READ;
                  bus.rd_en <= 1'b1;
                  bus.busy  <= 1'b1;
               end
            end
            READ: begin
               bus.rd_en <= 1'b0;
               state     <= LATCH;
            end
            LATCH: begin
               word  <= bus.rd_data;
               idx   <= 2'd1;
               state <= SEND;
            end
            SEND: if (byte_ready && idx == 2'd0) begin
`ifdef UART_DUMP_CSUM_EN
               state <= NEXT;
`else
               if (last_word) begin
                  state    <= FIN;
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
               end else state <= NEXT;
`endif
            end else if (byte_valid) idx <= idx + 1'b1;
            NEXT: begin
               bus.rd_adr <= bus.rd_adr + 1'b1;
               remaining  <= remaining - 1'b1;
`ifdef UART_DUMP_CSUM_EN
               if (last_word) begin
                  state <= CSUM;
                  gap   <= '0;
               end else begin
                  state     <= READ;
                  bus.rd_en <= 1'b1;
               end
`else
               state     <= READ;
               bus.rd_en <= 1'b1;
`endif
            end
`ifdef UART_DUMP_CSUM_EN
            CSUM: begin
               if (gap != 2'd2) gap <= gap + 1'b1;
               else if (byte_ready) begin
                  state    <= FIN;
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
               end
            end
`endif
            FIN: begin
               bus.done <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
   uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
      .clk  (clk),
      .rst  (rst),
      .valid(byte_valid),
      .data (byte_data),
      .ready(byte_ready),
      .tx   (bus.tx)
   );
endmodule
